pwm_capture: RTL
================

# pwm_capture

PWM capture and duty decoder: the receiving end of the team's PWM LED drivers. It samples an asynchronous PWM waveform, measures period and high time in `clk` cycles, and converts them into an unsigned duty code of the same form the drivers take as their compare value. It sits between an external or looped-back PWM pin and the control/status logic, for self-test of the LED PWM path and for reading PWM-coded sensors.

## Interface
- `CNT_W`, default 16: width of the period and high-time counters, in `clk` cycles.
- `DUTY_W`, default 10: width of the duty code.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `pwm_in`  input  1  PWM waveform, asynchronous to `clk`.
- `period_o`  output  `CNT_W`  last measured period, in cycles, rise to rise.
- `high_o`  output  `CNT_W`  last measured high time, in cycles, rise to fall.
- `duty_o`  output  `DUTY_W`  floor(`high_o` * 2^`DUTY_W` / `period_o`).
- `valid_o`  output  1  one-cycle pulse when `period_o`, `high_o` and `duty_o` update together.
- `timeout_o`  output  1  level; set while no rising edge has arrived within 2^`CNT_W`-1 cycles.
- `overrun_o`  output  1  one-cycle pulse when a completed period is dropped because the divider is busy.

## Operation
- **Input synchronizer**
  - `pwm_in` passes through a 2-flop synchronizer, giving `pwm_s`; a further flop gives `pwm_d`.
  - `rise = pwm_s & ~pwm_d` and `fall = ~pwm_s & pwm_d`.
  - There is no glitch filter.
- **Measurement counter `cnt`**
  - `cnt` is `CNT_W` bits wide.
  - It loads 1 on `rise`, otherwise increments, saturating at 2^`CNT_W`-1.
  - On `fall`, `hi_l` <= `cnt`.
  - On `rise` while measuring: `per_l` <= `cnt` and `hi_cap` <= `hi_l`.
  - Edges alternate after synchronization, so `hi_l` is always valid at the next `rise`.
- **Measurement FSM**
  - IDLE: entered after reset and after a timeout. No period is known yet. On `rise`, go to MEAS with `cnt`=1 and clear `timeout_o`.
  - MEAS: on `rise`, capture `per_l`/`hi_cap`.
    - If the divider is idle, start it.
    - If the divider is busy, drop the sample and pulse `overrun_o`.
    - In both cases stay in MEAS.
  - MEAS, when `cnt` reaches 2^`CNT_W`-1 with no `rise` (timeout): go to IDLE. At that edge:
    - `period_o` = 0 and `high_o` = 0.
    - `duty_o` = all ones if `pwm_s` = 1, else 0.
    - `timeout_o` = 1.
    - `valid_o` pulses.
    - `cnt` then holds saturated until the next `rise`.
- **Divider**
  - Restoring, serial, `DUTY_W` iterations, with a `CNT_W`+1-bit remainder.
  - Start: `r` = `hi_cap`, `d` = `per_l`.
  - Each iteration: `r` = `r`<<1; if `r` >= `d`, then `r` -= `d` and the quotient bit = 1, else 0. Quotient bits are produced MSB first.
  - Since `hi_cap` < `per_l`, the quotient always fits in `DUTY_W` bits; no clipping is needed.
  - On completion, `period_o` <= `per_l`, `high_o` <= `hi_cap`, `duty_o` <= quotient, and `valid_o` pulses.
- **Reset**
  - `rst_n` low clears, immediately: synchronizer flops, `cnt`, latches, divider state, FSM (to IDLE) and all outputs.
  - A division in progress is discarded without `valid_o`.

## Timing
- **Reset values:** `period_o`=0, `high_o`=0, `duty_o`=0, `valid_o`=0, `timeout_o`=0, `overrun_o`=0.
- **Input latency:** a `pwm_in` edge sampled at clock edge k is seen as `rise`/`fall` in the cycle after edge k+1. Capture happens at edge k+2 (call this edge C).
- **Divider:** runs on edges C+1 through C+`DUTY_W`. Outputs update and `valid_o` is high after edge C+`DUTY_W`+1, for exactly one cycle.
- **Busy window:** the divider counts as busy for the capture at any edge in C+1 … C+`DUTY_W`+1.
- **Overrun:** a period P ≥ `DUTY_W`+2 never overruns. A shorter period drops alternate samples.
- **First result:** the first `rise` after reset or timeout only arms measurement. The first `valid_o` follows the second `rise`.
- **Measured values:** period P cycles gives `period_o` = P. High time H gives `high_o` = H.
  - Both are exact to ±1 cycle of synchronizer phase for asynchronous input.
  - Both are exact for input generated synchronously to `clk`.
- **Simultaneous events:** if a timeout and a divider completion coincide on the same edge, the timeout values take priority.

## Test plan
- **Basic measurement:** reset, then a synchronous PWM with high time 25 and period 100 (`CNT_W`=16, `DUTY_W`=10). Required response: no `valid_o` after the first rise; after the second rise, `period_o`=100, `high_o`=25, `duty_o`=256 and one `valid_o` pulse. This repeats every 100 cycles.
- **Minimum non-overrun period:** period 12, high time 11. Required response: `duty_o`=938, `overrun_o` never asserts, and `valid_o` pulses every 12 cycles.
- **Overrun:** period 8, high time 4. Required response: `overrun_o` pulses on alternate rises; `valid_o` pulses every 16 cycles with `period_o`=8 and `duty_o`=512.
- **Stuck high:** hold `pwm_in`=1 for 70000 cycles after one rise. Required response: after 65535 cycles with no rise, `timeout_o`=1, `duty_o`=1023, `period_o`=0, `high_o`=0 and one `valid_o` pulse. The next PWM rise clears `timeout_o`, and the rise after that produces a fresh measurement.
- **Stuck low:** hold `pwm_in`=0 through a timeout. Required response: `duty_o`=0 and `timeout_o`=1.
- **Reset mid-division:** pull `rst_n` low 3 cycles into a division. Required response: all outputs are 0 immediately and no `valid_o` appears. After release, two rises are needed before the next `valid_o`.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture and duty decoder: measures period and high time of an asynchronous
// PWM input in clk cycles and converts them into a DUTY_W-bit duty code.
module pwm_capture #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned DUTY_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  period_o,
   output logic [CNT_W-1:0]  high_o,
   output logic [DUTY_W-1:0] duty_o,
   output logic              valid_o,
   output logic              timeout_o,
   output logic              overrun_o
);
   localparam int unsigned      IT_W    = $clog2(DUTY_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, MEAS} state_t;
   state_t state, state_nxt;

   logic              pwm_m, pwm_s, pwm_d;
   logic              rise_c, fall_c;
   logic [CNT_W-1:0]  cnt, hi_l, per_l, hi_cap;
   logic              div_busy;
   logic [IT_W-1:0]   div_it;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W:0]    rem_sh_c;
   logic              q_bit_c;
   logic [DUTY_W-1:0] quo;
   logic              div_done_c;
   logic              arm_c, start_c, drop_c, tmo_c;

   // Two-flop synchronizer plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_m <= 1'b0;
         pwm_s <= 1'b0;
         pwm_d <= 1'b0;
      end else begin
         pwm_m <= pwm_in;
         pwm_s <= pwm_m;
         pwm_d <= pwm_s;
      end
   end

   assign rise_c = pwm_s & ~pwm_d;
   assign fall_c = ~pwm_s & pwm_d;

   // Measurement counter: restarts at 1 on each rise, saturates at all ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         hi_l <= '0;
      end else begin
         if (rise_c)
            cnt <= CNT_W'(1);
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
         if (fall_c)
            hi_l <= cnt;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rise_c) state_nxt = MEAS;
         MEAS: if (!rise_c && cnt == CNT_MAX) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM decoded controls
   always_comb begin
      arm_c   = 1'b0;
      start_c = 1'b0;
      drop_c  = 1'b0;
      tmo_c   = 1'b0;
      case (state)
         IDLE: arm_c = rise_c;
         MEAS: begin
            if (rise_c) begin
               if (div_busy) drop_c  = 1'b1;
               else          start_c = 1'b1;
            end else if (cnt == CNT_MAX) begin
               tmo_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Restoring divider step: remainder stays below the divisor, so CNT_W bits hold it
   assign rem_sh_c   = {rem, 1'b0};
   assign q_bit_c    = rem_sh_c >= {1'b0, per_l};
   assign div_done_c = div_busy && (div_it == IT_W'(DUTY_W));

   // Capture latches, serial divider and registered outputs; timeout overrides completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_l     <= '0;
         hi_cap    <= '0;
         rem       <= '0;
         quo       <= '0;
         div_busy  <= 1'b0;
         div_it    <= '0;
         period_o  <= '0;
         high_o    <= '0;
         duty_o    <= '0;
         valid_o   <= 1'b0;
         timeout_o <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         valid_o   <= 1'b0;
         overrun_o <= drop_c;
         if (start_c) begin
            per_l    <= cnt;
            hi_cap   <= hi_l;
            rem      <= hi_l;
            quo      <= '0;
            div_busy <= 1'b1;
            div_it   <= '0;
         end else if (div_done_c) begin
            div_busy <= 1'b0;
            period_o <= per_l;
            high_o   <= hi_cap;
            duty_o   <= quo;
            valid_o  <= 1'b1;
         end else if (div_busy) begin
            rem    <= q_bit_c ? CNT_W'(rem_sh_c - {1'b0, per_l}) : CNT_W'(rem_sh_c);
            quo    <= DUTY_W'({quo, q_bit_c});
            div_it <= div_it + IT_W'(1);
         end
         if (arm_c)
            timeout_o <= 1'b0;
         if (tmo_c) begin
            period_o  <= '0;
            high_o    <= '0;
            duty_o    <= pwm_s ? '1 : '0;
            timeout_o <= 1'b1;
            valid_o   <= 1'b1;
         end
      end
   end
endmodule
